ram_bus_bridge: RTL and testbench
=================================

# ram_bus_bridge

Data-memory bridge between the Uranus core's single-cycle `ram_*` port and a variable-latency request/acknowledge memory bus. It replaces the zero-wait-state synchronous RAM model used in simulation. Each core access is converted into one bus transaction, and the core is frozen through its `halt` input until the transaction completes. A watchdog aborts transactions that are never acknowledged.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width. Fixed at 32; byte enables are 4 bits.
- `TIMEOUT`, 255: number of bus wait cycles allowed before a transaction is aborted. Legal range 1–65535.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on an aborted read.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `ram_en`, in, 1: core access request.
- `ram_write_en`, in, 4: byte write enables. All zero means a read.
- `ram_addr`, in, 32: core address.
- `ram_write_data`, in, 32: core store data.
- `ram_read_data`, out, 32: load data returned to the core.
- `halt`, out, 1: connects to the core's `halt`; freezes the pipeline.
- `bus_req`, out, 1: bus request, held high until `bus_ack`.
- `bus_we`, out, 4: latched byte enables.
- `bus_addr`, out, 32: latched address.
- `bus_wdata`, out, 32: latched store data.
- `bus_ack`, in, 1: one-cycle completion strobe from the bus.
- `bus_rdata`, in, 32: read data, valid when `bus_ack` is high.
- `bus_err`, out, 1: sticky flag set by a timeout.

## Operation
- FSM with three states: IDLE, WAIT, DONE.
- IDLE:
  - If `ram_en=1`: latch `ram_write_en`, `ram_addr` and `ram_write_data` into the `bus_*` registers, clear the wait counter, go to WAIT.
  - `halt` is combinationally high in this same cycle (`halt = (state==IDLE & ram_en) | state==WAIT`).
  - If `ram_en=0`: stay in IDLE.
- WAIT:
  - `bus_req=1`; `bus_*` are stable; the counter increments each cycle.
  - On `bus_ack=1`: if the access was a read, capture `bus_rdata` into `ram_read_data`; go to DONE.
  - If the counter reaches `TIMEOUT` without `bus_ack`: a read loads `ERR_DATA`, a write updates nothing; set `bus_err`; go to DONE.
  - If `bus_ack` and timeout occur in the same cycle, `bus_ack` wins and `bus_err` is not set.
- DONE:
  - `halt=0` and `bus_req=0`. The core advances at the end of this cycle.
  - The request still presented by the core this cycle is the one just serviced and is ignored.
  - Always return to IDLE.
- `ram_read_data` is a register. It changes only on a read completion (ack or timeout) and otherwise holds its last value, so it stays valid in the cycle after DONE.
- Writes never modify `ram_read_data`.
- `bus_ack` outside WAIT is ignored.
- `bus_err` clears only on reset.
- The core holds `ram_en`, `ram_addr`, `ram_write_en` and `ram_write_data` stable while `halt=1`. The bridge relies on this but uses only its latched copies on the bus.

## Timing
- Reset values: state IDLE, `bus_req=0`, `bus_we=0`, `bus_addr=0`, `bus_wdata=0`, `ram_read_data=0`, `bus_err=0`, `halt=0` (once `ram_en=0`).
- Reset assertion mid-transaction drops `bus_req` immediately (asynchronous). A late `bus_ack` after reset release is ignored.
- The request is seen in cycle T. `bus_req` is high from T+1.
- With `bus_ack` in cycle T+k (k≥1):
  - DONE occurs in T+k+1.
  - `halt` is high in T..T+k and low in T+k+1.
- The minimum stall is 2 cycles (ack in T+1). Each access costs k+2 cycles.
- A timeout fires in cycle T+`TIMEOUT` if no ack has arrived. DONE follows the next cycle.
- Back-to-back accesses: a new request may be accepted in the cycle after DONE. There is no gap beyond DONE.
- The wait counter is 16 bits wide.

## Structure
- Shared package `uranus_bus_pkg`:
  - FSM state enum {IDLE, WAIT, DONE}.
  - Default `ERR_DATA`.
  - A byte-enable width constant shared with the core's `ram_write_en`.
- A single module; no sub-modules. The watchdog counter is small enough to stay inline.

## Test plan
- Reset with `ram_en=0`, then release: all outputs stay at their reset values, and `halt=0` for 10 cycles.
- Read at 0x0000_0040; bus acks 3 cycles after `bus_req` rises with `bus_rdata`=0x1234_5678:
  - `halt` is high for 4 cycles, then low for one (DONE).
  - `ram_read_data`=0x1234_5678 from DONE onward.
- Write of 0xAABB_CCDD with `ram_write_en`=4'b0011 to 0x100, immediate ack:
  - `bus_we`=0011, `bus_addr`=0x100, `bus_wdata`=0xAABB_CCDD while `bus_req=1`.
  - `ram_read_data` is unchanged; total stall is 2 cycles.
- Read with `TIMEOUT`=4 and no ack:
  - `bus_req` is high for 4 cycles.
  - Then `ram_read_data`=0xDEAD_BEEF, `bus_err`=1 (sticky); the next access completes normally.
- Ack arriving in the same cycle the counter reaches `TIMEOUT`:
  - The ack data is returned and `bus_err` stays 0.
- Async reset asserted during WAIT:
  - `bus_req` and `halt` fall before the next clock edge.
  - A `bus_ack` pulse after reset release causes no state change.

Source files
------------

// File: rtl/uranus_bus_pkg.sv
// Shared definitions for the Uranus data-memory bus bridge.
package uranus_bus_pkg;

  localparam int BE_W = 4;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } bus_state_e;

endpackage

// File: rtl/ram_bus_bridge.sv
// Converts single-cycle core ram_* accesses into request/acknowledge bus
// transactions, stalling the core via halt and aborting unacknowledged ones.
module ram_bus_bridge
  import uranus_bus_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_en,
  input  logic [BE_W-1:0]   ram_write_en,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_write_data,
  output logic [DATA_W-1:0] ram_read_data,
  output logic              halt,
  output logic              bus_req,
  output logic [BE_W-1:0]   bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err,
  output logic [1:0]        dbg_state
);

  // Counter value seen in the cycle where the watchdog fires: the first WAIT
  // cycle holds 0, so TIMEOUT wait cycles end at TIMEOUT-1.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  // Handshake: bus_req stays high in every WAIT cycle with bus_we/addr/wdata
  // stable; a one-cycle bus_ack in WAIT completes the transfer, acks elsewhere
  // are dropped.
  bus_state_e        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [BE_W-1:0]   we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              is_read;

  assign is_read = (we_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (ram_en) begin
          we_d    = ram_write_en;
          addr_d  = ram_addr;
          wdata_d = ram_write_data;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (bus_ack) begin
          if (is_read) rdata_d = bus_rdata;
          state_d = ST_DONE;
        end else if (cnt_q == TO_LAST) begin
          if (is_read) rdata_d = ERR_DATA;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      // The core still presents the just-serviced request here; ignore it.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign halt          = ((state_q == ST_IDLE) && ram_en) || (state_q == ST_WAIT);
  assign bus_req       = (state_q == ST_WAIT);
  assign bus_we        = we_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign ram_read_data = rdata_q;
  assign bus_err       = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ram_bus_bridge.sv
// Directed bench for ram_bus_bridge: a cycle-timeline model of each access
// is compared against the DUT outputs on every falling edge.
module tb_ram_bus_bridge;

  localparam int          TP  = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        halt;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic [1:0]  dbg_state;

  ram_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TP), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst),
    .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
    .halt(halt), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // expected-output model
  logic        m_halt, m_req, m_err;
  logic [3:0]  m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [31:0] exp_q[$];
  bit          chk_en = 0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_halt = 0; m_req = 0; m_err = 0;
    m_we = '0; m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("halt", {31'd0, halt}, {31'd0, m_halt});
      check("bus_req", {31'd0, bus_req}, {31'd0, m_req});
      check("bus_we", {28'd0, bus_we}, {28'd0, m_we});
      check("bus_addr", bus_addr, m_addr);
      check("bus_wdata", bus_wdata, m_wdata);
      check("ram_read_data", ram_read_data, m_rdata);
      check("bus_err", {31'd0, bus_err}, {31'd0, m_err});
    end
  end

  // driver: one core access; ack_k = wait cycle of the ack (0 = never acked)
  task automatic access(input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ack_k,
                        input logic [31:0] rdata, output int stall, output int reqc);
    bit fin;
    bit acked;
    stall = 1; reqc = 0; fin = 0; acked = 0;
    ram_en = 1; ram_write_en = we; ram_addr = addr; ram_write_data = wdata;
    m_halt = 1; m_req = 0;
    @(posedge clk); #1;
    m_we = we; m_addr = addr; m_wdata = wdata;
    for (int j = 1; !fin; j++) begin
      m_req = 1; m_halt = 1;
      if (j > 1) stall++;
      reqc++;
      acked = (j == ack_k);
      bus_ack = acked;
      bus_rdata = acked ? rdata : $urandom;
      fin = acked || (j == TP);
      @(posedge clk); #1;
    end
    stall++;
    bus_ack = 0;
    m_req = 0; m_halt = 0;
    if (we == 4'b0000) begin
      m_rdata = acked ? rdata : ERR;
      exp_q.push_back(m_rdata);
    end
    if (!acked) m_err = 1;
    @(posedge clk); #1;
    ram_en = 0;
    m_halt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_read(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, ram_read_data, e);
    end
  endtask

  initial begin
    int st, rq;
    rst = 0; ram_en = 0; ram_write_en = 0; ram_addr = 0; ram_write_data = 0;
    bus_ack = 0; bus_rdata = 0;
    model_reset();

    // reset and idle
    repeat (3) @(posedge clk);
    #1 rst = 1;
    chk_en = 1;
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    check("reset_rdata", ram_read_data, 32'd0);
    idle(10);

    // read, ack 3 cycles after bus_req rises
    access(4'b0000, 32'h0000_0040, 32'h0, 3, 32'h1234_5678, st, rq);
    check("read_stall", st, 32'd4);
    check("read_data_lit", ram_read_data, 32'h1234_5678);
    check_read("read_sb");
    idle(2);

    // write with immediate ack
    access(4'b0011, 32'h0000_0100, 32'hAABB_CCDD, 1, 32'hFFFF_FFFF, st, rq);
    check("write_stall", st, 32'd2);
    check("write_keeps_rdata", ram_read_data, 32'h1234_5678);
    idle(1);

    // ack in the same cycle the watchdog would fire
    access(4'b0000, 32'h0000_0180, 32'h0, TP, 32'h55AA_33CC, st, rq);
    check("tie_data", ram_read_data, 32'h55AA_33CC);
    check("tie_no_err", {31'd0, bus_err}, 32'd0);
    check_read("tie_sb");
    idle(1);

    // timeout on a read
    access(4'b0000, 32'h0000_0200, 32'h0, 0, 32'h0, st, rq);
    check("timeout_req_cycles", rq, 32'd4);
    check("timeout_data", ram_read_data, ERR);
    check("timeout_err", {31'd0, bus_err}, 32'd1);
    check_read("timeout_sb");

    // back-to-back: next access completes normally, err stays sticky
    access(4'b0000, 32'h0000_0204, 32'h0, 2, 32'h0BAD_F00D, st, rq);
    check_read("after_timeout_sb");
    access(4'b1111, 32'h0000_0208, 32'h0102_0304, 1, 32'h0, st, rq);
    check("b2b_write_keeps", ram_read_data, 32'h0BAD_F00D);
    check("err_sticky", {31'd0, bus_err}, 32'd1);
    access(4'b0000, 32'h0000_020C, 32'h0, 1, 32'hCAFE_0001, st, rq);
    check_read("b2b_read_sb");
    idle(2);

    // async reset during WAIT
    ram_en = 1; ram_write_en = 0; ram_addr = 32'h300; ram_write_data = 0;
    m_halt = 1; m_req = 0;
    @(posedge clk); #1;
    m_req = 1; m_we = 4'b0000; m_addr = 32'h300; m_wdata = 32'h0;
    #1;
    rst = 0; ram_en = 0;
    model_reset();
    #1;
    check("async_req_low", {31'd0, bus_req}, 32'd0);
    check("async_halt_low", {31'd0, halt}, 32'd0);
    check("async_err_clear", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #1 rst = 1;
    bus_ack = 1; bus_rdata = 32'h7777_7777;
    @(posedge clk); #1 bus_ack = 0;
    idle(3);
    check("late_ack_state", {30'd0, dbg_state}, 32'd0);
    check("late_ack_rdata", ram_read_data, 32'd0);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
